// File: rtl/pulse_generator_pkg.sv
// Shared types and widths for the GPS-scheduled pulse generator.
package pulse_generator_pkg;

  localparam int YEAR_W     = 16;
  localparam int FIELD_W    = 8;
  localparam int WIDTH_W    = 32;
  localparam int ENABLE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_gen_pps_sync.sv
// Two-flop synchronizer for the raw PPS input followed by a registered rising-edge detector.
module pulse_gen_pps_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pps_raw_i,
  output logic pps_edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      sync1_q     <= pps_raw_i;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign pps_edge_o = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/pulse_generator.sv
// Periodic pulse train that starts on the PPS edge labelled by a matching GPS packet
// and re-aligns its phase to every following PPS edge.
//
// state   | meaning
// IDLE    | waiting for an enabled packet whose time equals the user start time
// ARMED   | widths latched, waiting for the PPS edge the packet labelled
// RUNNING | generating pulses, phase cleared on every PPS edge
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int unsigned CLKS_PER_1_US = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_pulse_enable,
  input  logic               i_pps_raw,
  input  logic [YEAR_W-1:0]  i_usr_year,
  input  logic [FIELD_W-1:0] i_usr_month,
  input  logic [FIELD_W-1:0] i_usr_day,
  input  logic [FIELD_W-1:0] i_usr_hour,
  input  logic [FIELD_W-1:0] i_usr_minutes,
  input  logic [FIELD_W-1:0] i_usr_seconds,
  input  logic [WIDTH_W-1:0] i_width_high,
  input  logic [WIDTH_W-1:0] i_width_period,
  input  logic               i_thunder_packet_dv,
  input  logic [YEAR_W-1:0]  i_thunder_year,
  input  logic [FIELD_W-1:0] i_thunder_month,
  input  logic [FIELD_W-1:0] i_thunder_day,
  input  logic [FIELD_W-1:0] i_thunder_hour,
  input  logic [FIELD_W-1:0] i_thunder_minutes,
  input  logic [FIELD_W-1:0] i_thunder_seconds,
  output logic               o_pulse_out
);

  localparam logic [31:0] PRESC_MAX = 32'(CLKS_PER_1_US - 1);

  state_e             state_q,  state_d;
  logic [31:0]        presc_q,  presc_d;
  logic [WIDTH_W-1:0] phase_q,  phase_d;
  logic [WIDTH_W-1:0] high_q,   high_d;
  logic [WIDTH_W-1:0] period_q, period_d;
  logic               pulse_q,  pulse_d;
  logic               pps_edge;
  logic               time_match;
  logic               unused_en_bits;

  assign unused_en_bits = ^i_pulse_enable[7:ENABLE_BIT+1];

  pulse_gen_pps_sync u_pps_sync (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .pps_raw_i  (i_pps_raw),
    .pps_edge_o (pps_edge)
  );

  assign time_match = (i_thunder_year    == i_usr_year)    &&
                      (i_thunder_month   == i_usr_month)   &&
                      (i_thunder_day     == i_usr_day)     &&
                      (i_thunder_hour    == i_usr_hour)    &&
                      (i_thunder_minutes == i_usr_minutes) &&
                      (i_thunder_seconds == i_usr_seconds);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    high_d   = high_q;
    period_d = period_q;
    pulse_d  = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        phase_d = '0;
        if (i_thunder_packet_dv && time_match) begin
          state_d  = ARMED;
          high_d   = i_width_high;
          period_d = i_width_period;
        end
      end
      ARMED: begin
        if (pps_edge) begin
          state_d = RUNNING;
          presc_d = '0;
          phase_d = '0;
        end
      end
      RUNNING: begin
        if (pps_edge) begin
          presc_d = '0;
          phase_d = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          phase_d = (phase_q >= period_q - 1'b1) ? '0 : phase_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_pulse_enable[ENABLE_BIT]) begin
      state_d = IDLE;
      presc_d = '0;
      phase_d = '0;
    end

    // Output is registered from the next phase so the first high cycle lines up with the PPS edge.
    pulse_d = (state_d == RUNNING) && (period_d != '0) && (phase_d < high_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      phase_q  <= '0;
      high_q   <= '0;
      period_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      high_q   <= high_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_pulse_out = pulse_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Randomized and directed bench for pulse_generator against an elapsed-time reference model.
module tb_pulse_generator;

  localparam int CPU = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pulse_enable;
  logic        pps_raw;
  logic [15:0] usr_year, thunder_year;
  logic [7:0]  usr_month, usr_day, usr_hour, usr_minutes, usr_seconds;
  logic [7:0]  thunder_month, thunder_day, thunder_hour, thunder_minutes, thunder_seconds;
  logic [31:0] width_high, width_period;
  logic        thunder_dv;
  logic        pulse_out;

  always #50 clk = ~clk;

  pulse_generator #(.CLKS_PER_1_US(CPU)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_pulse_enable      (pulse_enable),
    .i_pps_raw           (pps_raw),
    .i_usr_year          (usr_year),
    .i_usr_month         (usr_month),
    .i_usr_day           (usr_day),
    .i_usr_hour          (usr_hour),
    .i_usr_minutes       (usr_minutes),
    .i_usr_seconds       (usr_seconds),
    .i_width_high        (width_high),
    .i_width_period      (width_period),
    .i_thunder_packet_dv (thunder_dv),
    .i_thunder_year      (thunder_year),
    .i_thunder_month     (thunder_month),
    .i_thunder_day       (thunder_day),
    .i_thunder_hour      (thunder_hour),
    .i_thunder_minutes   (thunder_minutes),
    .i_thunder_seconds   (thunder_seconds),
    .o_pulse_out         (pulse_out)
  );

  int cyc = 0;
  int pps_next = 133;
  int pps_int = 1000;
  int npass = 0;
  int nchk = 0;

  // Reference model: tracks which clock edge started the train and derives the
  // output from elapsed time, rather than from counters.
  int          mstate = 0;  // 0 idle, 1 armed, 2 running
  int unsigned mhigh = 0, mper = 0;
  int          mstart = 0;
  bit [2:0]    hist = '0;   // raw PPS samples, hist[0] newest
  bit          exp_out = 1'b0;

  always @(posedge clk) begin
    bit ppse;
    bit match;
    int unsigned el;
    cyc++;
    ppse = hist[1] & ~hist[2];
    if (rst) begin
      mstate  = 0;
      hist    = '0;
      exp_out = 1'b0;
    end else begin
      hist  = {hist[1:0], pps_raw};
      match = (thunder_year == usr_year) && (thunder_month == usr_month) &&
              (thunder_day == usr_day) && (thunder_hour == usr_hour) &&
              (thunder_minutes == usr_minutes) && (thunder_seconds == usr_seconds);
      if (!pulse_enable[0]) mstate = 0;
      else begin
        case (mstate)
          0: if (thunder_dv && match) begin
               mstate = 1; mhigh = width_high; mper = width_period;
             end
          1: if (ppse) begin mstate = 2; mstart = cyc; end
          default: if (ppse) mstart = cyc;
        endcase
      end
      el = int'(cyc - mstart) / CPU;
      exp_out = (mstate == 2) && (mper != 0) && ((el % mper) < mhigh);
    end
  end

  task automatic step();
    @(negedge clk);
    nchk++;
    assert (pulse_out === exp_out) npass++;
    else $error("FAIL pulse_out cyc=%0d observed=%0b expected=%0b", cyc, pulse_out, exp_out);
    if (cyc == pps_next) pps_raw = 1'b1;
    else if (cyc == pps_next + 3) begin
      pps_raw  = 1'b0;
      pps_next = pps_next + pps_int;
    end
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic run_for(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_packet(input int y, input int mo, input int d, input int h,
                             input int mi, input int s);
    thunder_year    = 16'(y);
    thunder_month   = 8'(mo);
    thunder_day     = 8'(d);
    thunder_hour    = 8'(h);
    thunder_minutes = 8'(mi);
    thunder_seconds = 8'(s);
    thunder_dv      = 1'b1;
    step();
    thunder_dv      = 1'b0;
  endtask

  task automatic set_usr();
    usr_year = 16'd2020; usr_month = 8'd7; usr_day = 8'd15;
    usr_hour = 8'd11; usr_minutes = 8'd55; usr_seconds = 8'd30;
  endtask

  task automatic go_idle(input int h, input int p);
    pulse_enable = 8'h00;
    step();
    pulse_enable = 8'h01;
    width_high   = 32'(h);
    width_period = 32'(p);
  endtask

  task automatic matching_packet();
    send_packet(2020, 7, 15, 11, 55, 30);
  endtask

  initial begin
    int f;
    int v[6];
    rst = 1'b1; pulse_enable = 8'h01; pps_raw = 1'b0; thunder_dv = 1'b0;
    set_usr();
    thunder_year = '0; thunder_month = '0; thunder_day = '0;
    thunder_hour = '0; thunder_minutes = '0; thunder_seconds = '0;
    width_high = 32'd2; width_period = 32'd8;
    run_for(3);
    rst = 1'b0;

    // Packets for seconds 28..31; only the one for :30 arms, start at the following PPS
    for (int k = 0; k < 4; k++) begin
      run_until(200 + 1000 * k);
      send_packet(2020, 7, 15, 11, 55, 28 + k);
      if (k == 2) begin
        usr_seconds  = 8'd0;
        width_high   = 32'd5;
        width_period = 32'd6;
      end
    end
    run_until(5300);
    set_usr();
    pps_int = 300;

    // Day mismatch never arms
    go_idle(2, 8);
    matching_packet();
    go_idle(2, 8);
    send_packet(2020, 7, 16, 11, 55, 30);
    run_for(900);

    // Enable drop mid-run, re-enable without a fresh packet
    go_idle(3, 5);
    matching_packet();
    run_for(700);
    pulse_enable = 8'h00;
    run_for(50);
    pulse_enable = 8'h01;
    run_for(700);

    // Degenerate widths
    go_idle(8, 8); matching_packet(); run_for(800);
    go_idle(0, 8); matching_packet(); run_for(700);
    go_idle(5, 0); matching_packet(); run_for(700);
    go_idle(1, 1); matching_packet(); run_for(700);

    // Packet in the same cycle as a PPS edge: arm only
    go_idle(3, 7);
    run_until(pps_next + 5);
    run_until(pps_next + 2);
    matching_packet();
    run_for(700);

    // Reset while running, later PPS must not restart
    go_idle(2, 4);
    matching_packet();
    run_for(600);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_for(800);

    // Randomized programming, timing, mismatches and enable drops
    for (int it = 0; it < 10; it++) begin
      pps_int = int'($urandom_range(150, 400));
      go_idle(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
      pulse_enable = {7'($urandom), 1'b1};
      run_for(int'($urandom_range(0, 300)));
      v = '{2020, 7, 15, 11, 55, 30};
      if ($urandom_range(0, 3) == 0) begin
        f = int'($urandom_range(0, 5));
        v[f] = v[f] + 1;
      end
      send_packet(v[0], v[1], v[2], v[3], v[4], v[5]);
      width_high   = $urandom_range(0, 10);
      width_period = $urandom_range(0, 10);
      run_for(int'($urandom_range(300, 800)));
      if ($urandom_range(0, 2) == 0) begin
        pulse_enable = 8'h00;
        run_for(int'($urandom_range(1, 20)));
        pulse_enable = 8'h01;
      end
      run_for(int'($urandom_range(100, 400)));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
